// File: rtl/nrdiv_pkg.sv
// rtl/nrdiv_pkg.sv - shared types and constants for the non-restoring divider
package nrdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
`ifdef NRDIV_SIGNED_EN
    , ST_SIGN = 2'd3
`endif
  } state_t;

  function automatic int nrdiv_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam logic [31:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/nrdiv_addsub.sv
// rtl/nrdiv_addsub.sv - WIDTH+1-bit modular adder/subtractor with sub select
module nrdiv_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] y
);

  assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/nonrestoring_divider.sv
// rtl/nonrestoring_divider.sv - multi-cycle non-restoring divider, start/done handshake
// Signed two's-complement operation is compiled in with NRDIV_SIGNED_EN.
module nonrestoring_divider
  import nrdiv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = nrdiv_cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH:0]   a, a_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic [WIDTH-1:0] d, d_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             dbz_pend, dbz_pend_nxt;
  logic [WIDTH-1:0] quotient_nxt, remainder_nxt;
  logic             dbz_nxt, busy_nxt, done_nxt;
  logic [WIDTH:0]   as_a, as_y, a_fix;
  logic             as_sub;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;

`ifdef NRDIV_SIGNED_EN
  logic neg_q, neg_q_nxt, neg_r, neg_r_nxt;
  assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
  assign dividend_mag = dividend;
  assign divisor_mag  = divisor;
`endif

  // ITER feeds the shifted {A,Q}; FIX reuses the same unit for the A+D correction.
  assign as_a   = (state == ST_ITER) ? {a[WIDTH-1:0], q[WIDTH-1]} : a;
  assign as_sub = (state == ST_ITER) ? ~a[WIDTH] : 1'b0;
  assign a_fix  = a[WIDTH] ? as_y : a;

  nrdiv_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (as_a),
    .b   ({1'b0, d}),
    .sub (as_sub),
    .y   (as_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      a           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      dbz_pend    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef NRDIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      a           <= a_nxt;
      q           <= q_nxt;
      d           <= d_nxt;
      cnt         <= cnt_nxt;
      dbz_pend    <= dbz_pend_nxt;
      quotient    <= quotient_nxt;
      remainder   <= remainder_nxt;
      div_by_zero <= dbz_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
`ifdef NRDIV_SIGNED_EN
      neg_q       <= neg_q_nxt;
      neg_r       <= neg_r_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    a_nxt         = a;
    q_nxt         = q;
    d_nxt         = d;
    cnt_nxt       = cnt;
    dbz_pend_nxt  = dbz_pend;
    quotient_nxt  = quotient;
    remainder_nxt = remainder;
    dbz_nxt       = div_by_zero;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
`ifdef NRDIV_SIGNED_EN
    neg_q_nxt     = neg_q;
    neg_r_nxt     = neg_r;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          busy_nxt = 1'b1;
          if (divisor == '0) begin
            // Zero divisor: park the raw dividend in Q and let FIX publish it.
            dbz_pend_nxt = 1'b1;
            q_nxt        = dividend;
            state_nxt    = ST_FIX;
          end else begin
            dbz_pend_nxt = 1'b0;
            a_nxt        = '0;
            q_nxt        = dividend_mag;
            d_nxt        = divisor_mag;
            cnt_nxt      = CW'(WIDTH);
            state_nxt    = ST_ITER;
`ifdef NRDIV_SIGNED_EN
            neg_q_nxt    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_nxt    = dividend[WIDTH-1];
`endif
          end
        end
      end
      ST_ITER: begin
        a_nxt   = as_y;
        q_nxt   = {q[WIDTH-2:0], ~as_y[WIDTH]};
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        if (dbz_pend) begin
          quotient_nxt  = DBZ_QUOTIENT[WIDTH-1:0];
          remainder_nxt = q;
          dbz_nxt       = 1'b1;
          done_nxt      = 1'b1;
          busy_nxt      = 1'b0;
          state_nxt     = ST_IDLE;
        end else begin
`ifdef NRDIV_SIGNED_EN
          a_nxt         = a_fix;
          state_nxt     = ST_SIGN;
`else
          quotient_nxt  = q;
          remainder_nxt = a_fix[WIDTH-1:0];
          dbz_nxt       = 1'b0;
          done_nxt      = 1'b1;
          busy_nxt      = 1'b0;
          state_nxt     = ST_IDLE;
`endif
        end
      end
`ifdef NRDIV_SIGNED_EN
      ST_SIGN: begin
        quotient_nxt  = neg_q ? -q : q;
        remainder_nxt = neg_r ? -a[WIDTH-1:0] : a[WIDTH-1:0];
        dbz_nxt       = 1'b0;
        done_nxt      = 1'b1;
        busy_nxt      = 1'b0;
        state_nxt     = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// tb/tb_nonrestoring_divider.sv - scoreboard bench for nonrestoring_divider (WIDTH=8)
module tb_nonrestoring_divider;

`ifdef NRDIV_SIGNED_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 9;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] dividend, divisor;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int errors = 0;
  int checks = 0;
  logic [16:0] sb[$];

  nonrestoring_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b);
    logic [31:0] qq, rr;
    if (b == 8'd0) return {8'hFF, a, 1'b1};
`ifdef NRDIV_SIGNED_EN
    begin
      int sa, sbv;
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      qq  = sa / sbv;
      rr  = sa % sbv;
    end
`else
    qq = {24'd0, a} / {24'd0, b};
    rr = {24'd0, a} % {24'd0, b};
`endif
    return {qq[7:0], rr[7:0], 1'b0};
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check_val("extra_done", 1, 0);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        check_val("quotient", quotient, e[16:9]);
        check_val("remainder", remainder, e[8:1]);
        check_val("div_by_zero", div_by_zero, e[0]);
        check_val("busy_with_done", busy, 0);
      end
    end
  end

  // Called at a negedge; the following posedge is the accepting edge E0.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input int inject_at, input int reset_at);
    int n, busy_n, exp_lat;
    logic got, aborted;
    exp_lat = (b == 8'd0) ? 1 : LAT;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    busy_n  = busy ? 1 : 0;
    n       = 0;
    got     = 1'b0;
    aborted = 1'b0;
    while (n < 40 && !got && !aborted) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == inject_at) begin
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (n == reset_at) begin
        reset = 1'b1;
        #1;
        check_val("rst_quotient", quotient, 0);
        check_val("rst_remainder", remainder, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        void'(sb.pop_front());
        aborted = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else if (done) begin
        got = 1'b1;
      end else if (busy) begin
        busy_n++;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      if (got) begin
        check_val("latency", n, exp_lat);
        check_val("busy_cycles", busy_n, exp_lat);
      end else begin
        check_val("timeout", 0, 1);
        sb.delete();
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check_val("reset_quotient", quotient, 0);
    check_val("reset_remainder", remainder, 0);
    check_val("reset_dbz", div_by_zero, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

`ifdef NRDIV_SIGNED_EN
    run_op(8'd156, 8'd7, 0, 0);   // -100 / 7
    run_op(8'h80, 8'hFF, 0, 0);   // -128 / -1
    run_op(8'd100, 8'hF9, 0, 0);  // 100 / -7
`endif
    run_op(8'd100, 8'd7, 0, 0);
    run_op(8'd5, 8'd0, 0, 0);
    run_op(8'd255, 8'd1, 0, 0);
    run_op(8'd3, 8'd200, 0, 0);   // issued in the previous done cycle
    run_op(8'd100, 8'd7, 3, 0);   // start at cycle 3 must be ignored
    repeat (12) @(negedge clk);
    run_op(8'd100, 8'd7, 0, 4);   // reset aborts mid-operation
    repeat (12) @(negedge clk);
    run_op(8'd9, 8'd2, 0, 0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_op(ra, rb, 0, 0);
    end
    repeat (3) @(negedge clk);
    check_val("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
